// File: rtl/riscv_fetch_stage.sv
// riscv_fetch_stage: instruction-fetch stage and IF/ID pipeline register.
// Holds the PC, presents it to instruction memory and captures the returned
// word into IF/ID. Honours the ID stall and the EX branch redirect, and runs
// a small IDLE/RUN/HALT FSM that starts on 'ligar' and stops at HALT_INSTR.
// Optional feature macro: FETCH_COUNT_EN adds a saturating 32-bit count of
// valid IF/ID loads on output fetch_count.
module riscv_fetch_stage #(
    parameter int                XLEN       = 32,
    parameter logic [XLEN-1:0]   RESET_PC   = '0,
    parameter logic [31:0]       HALT_INSTR = 32'h0000_0073,
    parameter logic [31:0]       NOP_INSTR  = 32'h0000_0013
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            ligar,
    input  logic            stall_id,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic            if_id_valid,
    output logic            running,
`ifdef FETCH_COUNT_EN
    output logic [31:0]     fetch_count,
`endif
    output logic            halted
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              running_q, running_d;
    logic              halted_q, halted_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   if_id_pc_q, if_id_pc_d;
    logic [31:0]       if_id_instr_q, if_id_instr_d;
    logic              if_id_valid_q, if_id_valid_d;
    logic              load_valid;
    logic [XLEN-1:0]   redirect_pc;

    // Redirect targets are word aligned: low two bits are forced to zero.
    assign redirect_pc = branch_target & {{(XLEN-2){1'b1}}, 2'b00};

    // State register plus registered running/halted decodes.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            halted_q  <= halted_d;
        end
    end

    // Next-state logic: start on ligar, stop on a fetched halt word,
    // resume from HALT only when an older instruction redirects.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ligar) state_d = ST_RUN;
            ST_RUN: begin
                if (!branch_taken && !stall_id && imem_rdata == HALT_INSTR)
                    state_d = ST_HALT;
            end
            ST_HALT: if (branch_taken) state_d = ST_RUN;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode of the next state, registered so running/halted are glitch free.
    always_comb begin
        running_d = (state_d == ST_RUN);
        halted_d  = (state_d == ST_HALT);
    end

    // PC and IF/ID next values: redirect beats stall, stall beats fetch.
    always_comb begin
        pc_d          = pc_q;
        if_id_pc_d    = if_id_pc_q;
        if_id_instr_d = if_id_instr_q;
        if_id_valid_d = if_id_valid_q;
        load_valid    = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    pc_d          = redirect_pc;
                    if_id_pc_d    = '0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else if (!stall_id) begin
                    if_id_pc_d    = pc_q;
                    if_id_valid_d = 1'b1;
                    load_valid    = 1'b1;
                    if (imem_rdata == HALT_INSTR) begin
                        if_id_instr_d = HALT_INSTR;
                    end else begin
                        if_id_instr_d = imem_rdata;
                        pc_d          = pc_q + {{(XLEN-3){1'b0}}, 3'd4};
                    end
                end
            end
            ST_HALT: begin
                if (branch_taken) begin
                    pc_d          = redirect_pc;
                    if_id_pc_d    = '0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end else if (!stall_id) begin
                    if_id_pc_d    = '0;
                    if_id_instr_d = NOP_INSTR;
                    if_id_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    // PC and IF/ID pipeline register.
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            if_id_pc_q    <= '0;
            if_id_instr_q <= NOP_INSTR;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            if_id_pc_q    <= if_id_pc_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count_q;

    // Saturating count of edges that load a valid instruction into IF/ID.
    always_ff @(posedge clock) begin
        if (reset)
            fetch_count_q <= '0;
        else if (load_valid && fetch_count_q != 32'hFFFF_FFFF)
            fetch_count_q <= fetch_count_q + 32'd1;
    end

    assign fetch_count = fetch_count_q;
`endif

    assign imem_addr   = pc_q;
    assign if_id_pc    = if_id_pc_q;
    assign if_id_instr = if_id_instr_q;
    assign if_id_valid = if_id_valid_q;
    assign running     = running_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Bench for riscv_fetch_stage: a word-addressed instruction memory model,
// per-cycle stimulus with expected outputs pushed to a queue and popped after
// each edge. Define FETCH_COUNT_EN to also check fetch_count.
module tb_riscv_fetch_stage;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        run;
        logic        halt;
        logic [31:0] fc;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        ligar;
    logic        stall_id;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_instr;
    logic        if_id_valid;
    logic        running;
    logic        halted;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    logic [31:0] imem [0:63];
    exp_t        exp_q[$];
    logic [31:0] exp_fc;
    int          n_checks;
    int          n_errors;
    int          cyc_no;

    // Clock.
    always #5 clock = ~clock;

    // Combinational instruction memory, word indexed.
    assign imem_rdata = imem[imem_addr[7:2]];

    riscv_fetch_stage dut (
        .clock         (clock),
        .reset         (reset),
        .ligar         (ligar),
        .stall_id      (stall_id),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .if_id_pc      (if_id_pc),
        .if_id_instr   (if_id_instr),
        .if_id_valid   (if_id_valid),
        .running       (running),
`ifdef FETCH_COUNT_EN
        .fetch_count   (fetch_count),
`endif
        .halted        (halted)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got 0x%08h expected 0x%08h", tag, cyc_no, got, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the expected post-edge state, then
    // pop and compare it one time unit after the edge.
    task automatic cyc(input logic l, input logic s, input logic b, input logic [31:0] t,
                       input logic r, input logic [31:0] e_addr, input logic [31:0] e_ipc,
                       input logic [31:0] e_instr, input logic e_v, input logic e_run,
                       input logic e_halt, input logic e_ld);
        exp_t e;
        ligar         = l;
        stall_id      = s;
        branch_taken  = b;
        branch_target = t;
        reset         = r;
        if (r)
            exp_fc = 32'd0;
        else if (e_ld && exp_fc != 32'hFFFF_FFFF)
            exp_fc = exp_fc + 32'd1;
        exp_q.push_back('{addr: e_addr, ipc: e_ipc, instr: e_instr, valid: e_v,
                          run: e_run, halt: e_halt, fc: exp_fc});
        @(posedge clock);
        #1;
        cyc_no++;
        e = exp_q.pop_front();
        check_eq("imem_addr",   imem_addr,          e.addr);
        check_eq("if_id_pc",    if_id_pc,           e.ipc);
        check_eq("if_id_instr", if_id_instr,        e.instr);
        check_eq("if_id_valid", {31'd0, if_id_valid}, {31'd0, e.valid});
        check_eq("running",     {31'd0, running},   {31'd0, e.run});
        check_eq("halted",      {31'd0, halted},    {31'd0, e.halt});
`ifdef FETCH_COUNT_EN
        check_eq("fetch_count", fetch_count,        e.fc);
`endif
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        cyc_no   = 0;
        exp_fc   = 32'd0;
        reset = 1'b1; ligar = 1'b0; stall_id = 1'b0; branch_taken = 1'b0; branch_target = '0;
        for (int i = 0; i < 64; i++) imem[i] = (32'(i) << 7) | 32'h13;
        imem[0] = 32'h0010_0093;
        imem[1] = 32'h0020_0113;
        imem[2] = 32'h0030_0193;
        imem[3] = 32'h0000_0073;

        // Reset for two cycles, then idle without ligar.
        //  l  s  b  tgt            r  addr          ipc           instr          v  run hlt ld
        cyc(0, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 0, 32'h0,     0, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        // Stall and branch are ignored in IDLE.
        cyc(0, 1, 1, 32'h80,        0, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        // ligar edge: enter RUN, nothing captured yet.
        cyc(1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h13,        0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h4,        32'h0,        32'h0010_0093, 1, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,         0, 32'h8,        32'h4,        32'h0020_0113, 1, 1, 0, 1);
        // Two stall cycles at pc=8.
        cyc(0, 1, 0, 32'h0,         0, 32'h8,        32'h4,        32'h0020_0113, 1, 1, 0, 0);
        cyc(0, 1, 0, 32'h0,         0, 32'h8,        32'h4,        32'h0020_0113, 1, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'hC,        32'h8,        32'h0030_0193, 1, 1, 0, 1);
        // Halt word at 0xC.
        cyc(0, 0, 0, 32'h0,         0, 32'hC,        32'hC,        32'h73,        1, 0, 1, 1);
        cyc(1, 0, 0, 32'h0,         0, 32'hC,        32'h0,        32'h13,        0, 0, 1, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'hC,        32'h0,        32'h13,        0, 0, 1, 0);
        cyc(0, 1, 0, 32'h0,         0, 32'hC,        32'h0,        32'h13,        0, 0, 1, 0);
        // Redirect out of HALT, with stall asserted and an unaligned target.
        cyc(0, 1, 1, 32'h43,        0, 32'h40,       32'h0,        32'h13,        0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h44,       32'h40,       32'h813,       1, 1, 0, 1);
        // Redirect in RUN, stall in the same cycle: branch wins.
        cyc(0, 1, 1, 32'h43,        0, 32'h40,       32'h0,        32'h13,        0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h44,       32'h40,       32'h813,       1, 1, 0, 1);
        cyc(0, 0, 0, 32'h0,         0, 32'h48,       32'h44,       32'h893,       1, 1, 0, 1);
        // PC wrap from 0xFFFFFFFC to 0.
        cyc(0, 0, 1, 32'hFFFF_FFFF, 0, 32'hFFFF_FFFC, 32'h0,       32'h13,        0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h0,        32'hFFFF_FFFC, 32'h1F93,     1, 1, 0, 1);
        cyc(0, 0, 1, 32'h21,        0, 32'h20,       32'h0,        32'h13,        0, 1, 0, 0);
        // Reset mid-RUN at pc=0x20, then restart from 0.
        cyc(0, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        cyc(1, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h13,        0, 1, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h4,        32'h0,        32'h0010_0093, 1, 1, 0, 1);
        // ligar in RUN is ignored.
        cyc(1, 0, 0, 32'h0,         0, 32'h8,        32'h4,        32'h0020_0113, 1, 1, 0, 1);
        // Simultaneous reset and ligar: reset wins, FSM stays IDLE.
        cyc(1, 0, 0, 32'h0,         1, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);
        cyc(0, 0, 0, 32'h0,         0, 32'h0,        32'h0,        32'h13,        0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
